// File: rtl/systolic_array_is_ctrl.sv
// Sequencer for the input-stationary systolic array: preload one input tile, stream weight vectors, flag psum outputs.
// Latency: a weight vector accepted in cycle t yields out_valid in cycle t+OUT_LATENCY (plus one per process_en-low cycle).
// Backpressure: a held out_valid without out_ready, or missing w_valid, drops process_en and freezes array, token pipe and counters.
module systolic_array_is_ctrl #(
    parameter int ARRAY_HEIGHT = 4,
    parameter int ARRAY_WIDTH  = 4,
    parameter int OUT_LATENCY  = 8,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] num_vectors,
    output logic                 busy,
    output logic                 done,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 w_valid,
    output logic                 w_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 input_en,
    output logic                 process_en
);

    // Reject geometries the sequencer cannot drive at elaboration time.
    if (ARRAY_HEIGHT < 1 || ARRAY_WIDTH < 1 || OUT_LATENCY < 1 || CNT_WIDTH < 1) begin : g_bad_param
        $error("systolic_array_is_ctrl: parameters must all be >= 1");
    end

    localparam int LW = $clog2(ARRAY_WIDTH + 1);
    localparam logic [LW-1:0] LOAD_LAST = LW'(ARRAY_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                 state_q,   state_d;
    logic [CNT_WIDTH-1:0]   num_q,     num_d;
    logic [CNT_WIDTH-1:0]   issued_q,  issued_d;
    logic [CNT_WIDTH-1:0]   emitted_q, emitted_d;
    logic [LW-1:0]          load_q,    load_d;
    logic [OUT_LATENCY-1:0] pipe_q,    pipe_d;

    // Pipe extended by one bit so a single-stage pipe needs no special case.
    logic [OUT_LATENCY:0]   pipe_ext;
    logic                   token_in;
    logic                   stall;
    logic                   out_xfer;

    // Next-state, counter and handshake logic; every output defaults to its idle value.
    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        issued_d   = issued_q;
        emitted_d  = emitted_q;
        load_d     = load_q;
        pipe_d     = pipe_q;
        pipe_ext   = '0;
        token_in   = 1'b0;
        in_ready   = 1'b0;
        input_en   = 1'b0;
        w_ready    = 1'b0;
        process_en = 1'b0;
        done       = 1'b0;

        busy      = (state_q != S_IDLE);
        out_valid = pipe_q[OUT_LATENCY-1];
        out_last  = out_valid && (emitted_q == num_q - 1'b1);
        stall     = out_valid && !out_ready;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_vectors != '0) begin
                        num_d     = num_vectors;
                        issued_d  = '0;
                        emitted_d = '0;
                        load_d    = '0;
                        state_d   = S_LOAD;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_LOAD: begin
                input_en = in_valid;
                in_ready = in_valid;
                if (in_valid) begin
                    load_d = load_q + 1'b1;
                    if (load_q == LOAD_LAST) begin
                        state_d = S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                process_en = w_valid && !stall;
                w_ready    = process_en;
                token_in   = 1'b1;
                if (process_en) begin
                    issued_d = issued_q + 1'b1;
                    if (issued_q + 1'b1 == num_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                process_en = !stall;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Token pipe mirrors the array pipeline and only advances with it.
        if (process_en) begin
            pipe_ext = {pipe_q, token_in};
            pipe_d   = pipe_ext[OUT_LATENCY-1:0];
        end

        out_xfer = out_valid && out_ready && process_en;
        if (out_xfer) begin
            emitted_d = emitted_q + 1'b1;
            if (out_last) begin
                state_d = S_DONE;
            end
        end
    end

    // State, counters and token pipe; synchronous active-low reset aborts any job.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            num_q     <= '0;
            issued_q  <= '0;
            emitted_q <= '0;
            load_q    <= '0;
            pipe_q    <= '0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            issued_q  <= issued_d;
            emitted_q <= emitted_d;
            load_q    <= load_d;
            pipe_q    <= pipe_d;
        end
    end

endmodule

// File: tb/tb_systolic_array_is_ctrl.sv
// Directed bench for systolic_array_is_ctrl with H=W=4, OUT_LATENCY=8.
// Each step drives one cycle of inputs and checks all control outputs against hand-derived windows.
// Cycle 0 of every job is the cycle in which start is presented.
module tb_systolic_array_is_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] num_vectors;
    logic        busy, done;
    logic        in_valid, in_ready;
    logic        w_valid, w_ready;
    logic        out_valid, out_ready, out_last;
    logic        input_en, process_en;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    systolic_array_is_ctrl #(
        .ARRAY_HEIGHT(4),
        .ARRAY_WIDTH (4),
        .OUT_LATENCY (8),
        .CNT_WIDTH   (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_vectors(num_vectors),
        .busy       (busy),
        .done       (done),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .w_valid    (w_valid),
        .w_ready    (w_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .input_en   (input_en),
        .process_en (process_en)
    );

    function automatic logic inr(input int c, input int lo, input int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    // Expected vector {busy, done, in_ready, input_en, process_en, w_ready, out_valid, out_last}.
    function automatic logic [7:0] ex(input logic b, input logic d, input logic ie, input logic pe,
                                      input logic wr, input logic ov, input logic ol);
        return {b, d, ie, ie, pe, wr, ov, ol};
    endfunction

    // One cycle: drive inputs just after the edge, check outputs mid-cycle.
    task automatic cyc(input string name, input int c, input logic st, input logic [15:0] nv,
                       input logic iv, input logic wv, input logic ordy, input logic rn,
                       input logic [7:0] exp_v);
        logic [7:0] obs;
        @(posedge clk);
        #1;
        start       = st;
        num_vectors = nv;
        in_valid    = iv;
        w_valid     = wv;
        out_ready   = ordy;
        rst_n       = rn;
        #1;
        obs = {busy, done, in_ready, input_en, process_en, w_ready, out_valid, out_last};
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s c%0d observed=%b expected=%b (busy,done,in_rdy,in_en,pe,w_rdy,ov,last)",
                    name, c, obs, exp_v);
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        num_vectors = '0;
        in_valid    = 1'b0;
        w_valid     = 1'b0;
        out_ready   = 1'b0;

        // Reset state.
        for (int c = 0; c < 2; c++)
            cyc("reset", c, 1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);

        // Baseline 3-vector job; a start during DRAIN must be ignored.
        for (int c = 0; c <= 18; c++)
            cyc("base", c, (c == 0) || (c == 8), 16'd3, 1'b1, 1'b1, 1'b1, 1'b1,
                ex(inr(c, 1, 16), c == 16, inr(c, 1, 4), inr(c, 5, 15), inr(c, 5, 7),
                   inr(c, 13, 15), c == 15));

        // Output backpressure in cycles 13-15 freezes the array.
        for (int c = 0; c <= 20; c++)
            cyc("oback", c, c == 0, 16'd3, 1'b1, 1'b1, !inr(c, 13, 15), 1'b1,
                ex(inr(c, 1, 19), c == 19, inr(c, 1, 4), inr(c, 5, 12) || inr(c, 16, 18),
                   inr(c, 5, 7), inr(c, 13, 18), c == 18));

        // Weight starvation for 2 cycles after the first vector delays every output by 2.
        for (int c = 0; c <= 19; c++)
            cyc("wgap", c, c == 0, 16'd3, 1'b1, !inr(c, 6, 7), 1'b1, 1'b1,
                ex(inr(c, 1, 18), c == 18, inr(c, 1, 4), (c == 5) || inr(c, 8, 17),
                   (c == 5) || inr(c, 8, 9), inr(c, 15, 17), c == 17));

        // in_valid toggling during LOAD: four accepts at 1,3,5,7, STREAM from 8.
        for (int c = 0; c <= 20; c++)
            cyc("ltog", c, c == 0, 16'd3, (c % 2) == 1, 1'b1, 1'b1, 1'b1,
                ex(inr(c, 1, 19), c == 19, inr(c, 1, 7) && ((c % 2) == 1), inr(c, 8, 18),
                   inr(c, 8, 10), inr(c, 16, 18), c == 18));

        // Zero-length job, with a second start while busy that must be ignored.
        for (int c = 0; c <= 3; c++)
            cyc("zero", c, c <= 1, (c == 0) ? 16'd0 : 16'd3, 1'b1, 1'b1, 1'b1, 1'b1,
                ex(c == 1, c == 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

        // Reset asserted in the first DRAIN cycle aborts the job.
        for (int c = 0; c <= 9; c++)
            cyc("rstmid", c, c == 0, 16'd3, 1'b1, 1'b1, 1'b1, c != 8,
                ex(inr(c, 1, 8), 1'b0, inr(c, 1, 4), inr(c, 5, 8), inr(c, 5, 7), 1'b0, 1'b0));

        // Fresh single-vector job after the abort.
        for (int c = 0; c <= 15; c++)
            cyc("one", c, c == 0, 16'd1, 1'b1, 1'b1, 1'b1, 1'b1,
                ex(inr(c, 1, 14), c == 14, inr(c, 1, 4), inr(c, 5, 13), c == 5,
                   c == 13, c == 13));

        // More vectors than pipeline depth: outputs start in STREAM, final weight and a transfer coincide.
        for (int c = 0; c <= 24; c++)
            cyc("long", c, c == 0, 16'd10, 1'b1, 1'b1, 1'b1, 1'b1,
                ex(inr(c, 1, 23), c == 23, inr(c, 1, 4), inr(c, 5, 22), inr(c, 5, 14),
                   inr(c, 13, 22), c == 22));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/systolic_array_is_ctrl.md
# systolic_array_is_ctrl

Sequencer for the input-stationary systolic array; it drives that array's `input_en` and `process_en` pins. It preloads one stationary input tile, then streams a programmed number of weight vectors through the array. It tracks every vector through the fixed array pipeline and flags the matching unskewed `psum_out` vector with a valid/ready handshake. Output backpressure and weight starvation freeze the whole array by dropping `process_en`, so no data is lost and no bubbles enter the pipe.

## Interface
- `ARRAY_HEIGHT`, 4, array rows (input lanes)
- `ARRAY_WIDTH`, 4, array columns; equals the number of input-load cycles
- `OUT_LATENCY`, 8, `process_en`-high cycles from a weight vector's acceptance to its psum vector at `psum_out`; must be ≥1
- `CNT_WIDTH`, 16, width of the vector counters

Ports (name, direction, width, meaning):
- `clk` in 1: the single clock.
- `rst_n` in 1: reset; synchronous, active-low.
- `start` in 1: begin a job; sampled only in IDLE.
- `num_vectors` in `CNT_WIDTH`: weight vectors in the job; latched on accepted `start`.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle completion pulse.
- `in_valid` / `in_ready`, in / out, 1 each: handshake on the input column for the array's `input_in`.
- `w_valid` / `w_ready`, in / out, 1 each: handshake on the weight vector for the array's `weight_in`.
- `out_valid` / `out_ready`, out / in, 1 each: handshake on the array's `psum_out`.
- `out_last` out 1: qualifies the final output vector of a job.
- `input_en` out 1: to the array.
- `process_en` out 1: to the array.

## Operation
- States: IDLE, LOAD, STREAM, DRAIN, DONE.
- **IDLE**
  - `start`=1 and `num_vectors`≠0: latch `num_vectors`, clear the counters, go to LOAD.
  - `start`=1 and `num_vectors`=0: go directly to DONE with no array activity.
- **LOAD**
  - `input_en` = `in_ready` = `in_valid`; `process_en`=0.
  - The load counter increments on each accepted column.
  - The ARRAY_WIDTH-th acceptance moves the FSM to STREAM.
- **STREAM**
  - `stall` = `out_valid` & !`out_ready`.
  - `process_en` = `w_valid` & !`stall`; `w_ready` = `process_en`.
  - Each accepted weight vector increments `issued` and shifts a 1 into the token pipe.
  - When `issued` reaches `num_vectors` on acceptance, go to DRAIN.
- **DRAIN**
  - `process_en` = !`stall`; zeros are shifted into the token pipe.
  - `w_ready`=0, `input_en`=0.
- **Token pipe**
  - OUT_LATENCY bits deep; shifts only when `process_en`=1.
  - `out_valid` = the tail bit.
  - An output transfers when `out_valid` & `out_ready` & `process_en`.
  - Each transfer increments `emitted`.
  - `out_last` = `out_valid` & (`emitted` == `num_vectors`−1).
- **Job end:** the transfer with `out_last` moves the FSM to DONE. DONE asserts `done` for one cycle, then returns to IDLE.
- **Idle outputs:** `in_ready`, `w_ready`, `input_en` and `process_en` are 0 outside their states.
- **Freezing:** while `process_en`=0 the array, token pipe and counters all hold. `psum_out` therefore stays stable while `out_valid` is held.
- `start` outside IDLE is ignored.
- `out_ready` → `process_en` is a combinational path; the downstream consumer must not depend combinationally on `process_en`.

## Timing
- All state updates happen on the rising `clk`.
- **Reset** (`rst_n`=0 at an edge), from any state including mid-job:
  - FSM returns to IDLE; token pipe and counters clear.
  - `busy`, `done`, `out_valid`, `out_last`, `in_ready`, `w_ready`, `input_en` and `process_en` are all 0.
  - The array contents are then don't-care, and the next job reloads them.
- **Latency:** a weight vector accepted in cycle t gives `out_valid` in cycle t+OUT_LATENCY, provided `process_en` stays high throughout. Each `process_en`-low cycle in between adds one cycle.
- **Job timeline:** `start` accepted in cycle 0 → LOAD from cycle 1. The first STREAM cycle follows the cycle of the last load acceptance.
- **Throughput:** with no stalls, one vector per cycle in STREAM and one output per cycle in DRAIN.
- **Simultaneous events:**
  - A final weight acceptance alongside an output transfer is legal; both counters update in the same cycle.
  - When OUT_LATENCY < `num_vectors`, outputs begin while the FSM is still in STREAM.
- **Counter range:** `num_vectors` = 2^CNT_WIDTH−1 must complete without counter wrap.

## Test plan
- H=W=4, OUT_LATENCY=8, `num_vectors`=3, all valids/readies held high, `start` in cycle 0 →
  - `input_en` high in cycles 1–4;
  - `process_en`/`w_ready` high in 5–7, drain in 8–15;
  - `out_valid` in 13–15, `out_last` in 15;
  - `done` in 16, `busy` low from 17.
- Same job with `out_ready`=0 in cycles 13–15 → `process_en`=0 and `out_valid` held in 13–15; outputs transfer in 16–18, `done` in 19.
- `w_valid` dropped for 2 cycles after the first vector → `process_en` low for 2 cycles; every output is delayed by 2 and exactly 3 outputs appear.
- `in_valid` toggling 1,0,1,0,… during LOAD → exactly 4 `input_en` pulses, and STREAM entered only after the 4th.
- `num_vectors`=0 → `busy` for 1 cycle, `done` pulse, no `input_en`/`process_en`; `start` while busy is ignored.
- `rst_n` low in the first DRAIN cycle → all outputs 0 on the next cycle. A fresh `num_vectors`=1 job then gives exactly one `out_valid` with `out_last`.
